// File: rtl/id_hazard_if.sv
// Decode-stage hazard bus: ID instruction fields and pipeline control in,
// stall/issue/forward-select/stall-count out.
interface id_hazard_if #(
  parameter int NUM_SRC    = 2,
  parameter int REG_IDX_W  = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  logic                           id_valid;
  logic [NUM_SRC*REG_IDX_W-1:0]   id_src_idx;
  logic [NUM_SRC-1:0]             id_src_used;
  logic                           id_reg_wr;
  logic [REG_IDX_W-1:0]           id_dest_idx;
  logic [1:0]                     id_class;
  logic                           pipe_hold;
  logic                           flush;
  logic                           stall;
  logic                           issue;
  logic [NUM_SRC*SEL_W-1:0]       fwd_sel;
  logic [CNT_W-1:0]               stall_count;

  modport master (
    output id_valid, id_src_idx, id_src_used, id_reg_wr, id_dest_idx,
           id_class, pipe_hold, flush,
    input  stall, issue, fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_src_idx, id_src_used, id_reg_wr, id_dest_idx,
           id_class, pipe_hold, flush,
    output stall, issue, fwd_sel, stall_count
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writers; per-operand
// youngest-producer match drives forwarding select and load/mul stalls.
module id_hazard_src_chk #(
  parameter int REG_IDX_W  = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 2
) (
  input  logic                                  used,
  input  logic [REG_IDX_W-1:0]                  idx,
  input  logic [PIPE_DEPTH-1:0]                 e_vld,
  input  logic [PIPE_DEPTH-1:0][REG_IDX_W-1:0]  e_dest,
  input  logic [PIPE_DEPTH-1:0][SEL_W-1:0]      e_rdy,
  output logic                                  hazard,
  output logic [SEL_W-1:0]                      sel
);
  logic found;

  // Lowest index is the youngest producer; once found, older matches are ignored.
  always_comb begin
    hazard = 1'b0;
    sel    = '0;
    found  = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (used && idx != '0 && !found && e_vld[k] && e_dest[k] == idx) begin
        found = 1'b1;
        if (SEL_W'(k + 1) >= e_rdy[k]) sel = SEL_W'(k + 1);
        else                           hazard = 1'b1;
      end
    end
  end
endmodule

module id_hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int REG_IDX_W  = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int ALU_READY  = 1,
  parameter int MUL_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_hazard_if.slave   bus
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  typedef struct packed {
    logic                 vld;
    logic [REG_IDX_W-1:0] dest;
    logic [SEL_W-1:0]     rdy;
  } ent_t;

  ent_t [PIPE_DEPTH:1]                   ent;
  ent_t                                  nxt;
  logic [CNT_W-1:0]                      cnt;
  logic [PIPE_DEPTH-1:0]                 e_vld;
  logic [PIPE_DEPTH-1:0][REG_IDX_W-1:0]  e_dest;
  logic [PIPE_DEPTH-1:0][SEL_W-1:0]      e_rdy;
  logic [NUM_SRC-1:0]                    haz;
  logic                                  stall;
  logic                                  issue;

  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_flat
    assign e_vld[k-1]  = ent[k].vld;
    assign e_dest[k-1] = ent[k].dest;
    assign e_rdy[k-1]  = ent[k].rdy;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    id_hazard_src_chk #(
      .REG_IDX_W (REG_IDX_W),
      .PIPE_DEPTH(PIPE_DEPTH),
      .SEL_W     (SEL_W)
    ) u_chk (
      .used  (bus.id_src_used[i]),
      .idx   (bus.id_src_idx[i*REG_IDX_W +: REG_IDX_W]),
      .e_vld (e_vld),
      .e_dest(e_dest),
      .e_rdy (e_rdy),
      .hazard(haz[i]),
      .sel   (bus.fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  assign stall           = bus.id_valid & (|haz);
  assign issue           = bus.id_valid & ~stall & ~bus.pipe_hold & ~bus.flush;
  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.stall_count = cnt;

  // Writes to x0 enter as bubbles so they can never be matched.
  always_comb begin
    nxt      = '0;
    nxt.vld  = issue & bus.id_reg_wr & (bus.id_dest_idx != '0);
    nxt.dest = bus.id_dest_idx;
    case (bus.id_class)
      2'd0:    nxt.rdy = SEL_W'(ALU_READY);
      2'd2:    nxt.rdy = SEL_W'(MUL_READY);
      default: nxt.rdy = SEL_W'(LOAD_READY);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      if (!bus.pipe_hold) begin
        ent[1] <= nxt;
        for (int k = 2; k <= PIPE_DEPTH; k++) begin
          ent[k] <= ent[k-1];
          // A flushed EX instruction dies on its way into stage 2.
          if (k == 2 && bus.flush) ent[k].vld <= 1'b0;
        end
      end else if (bus.flush) begin
        ent[1].vld <= 1'b0;
      end
      if (stall && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_id_hazard_scoreboard;
  localparam int NSRC = 2;
  localparam int RW   = 5;
  localparam int PD   = 3;
  localparam int CW   = 4;

  typedef struct {
    string      nm;
    logic       stall;
    logic       issue;
    logic [1:0] f0;
    logic [1:0] f1;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_hazard_if #(.NUM_SRC(NSRC), .REG_IDX_W(RW), .PIPE_DEPTH(PD), .CNT_W(CW)) bus ();

  id_hazard_scoreboard #(
    .NUM_SRC(NSRC), .REG_IDX_W(RW), .PIPE_DEPTH(PD),
    .ALU_READY(1), .MUL_READY(2), .LOAD_READY(3), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic void chk(input string nm, input string fld, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "stall", int'(bus.stall), int'(e.stall));
      chk(e.nm, "issue", int'(bus.issue), int'(e.issue));
      chk(e.nm, "fwd0",  int'(bus.fwd_sel[1:0]), int'(e.f0));
      chk(e.nm, "fwd1",  int'(bus.fwd_sel[3:2]), int'(e.f1));
      chk(e.nm, "cnt",   int'(bus.stall_count), int'(e.cnt));
    end
  end

  task automatic vec(input string nm, input logic rn, input logic v,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                     input logic wr, input logic [4:0] rd, input logic [1:0] cls,
                     input logic hold, input logic fl,
                     input logic es, input logic ei, input logic [1:0] ef0,
                     input logic [1:0] ef1, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rn;
    bus.id_valid    = v;
    bus.id_src_idx  = {a1, a0};
    bus.id_src_used = used;
    bus.id_reg_wr   = wr;
    bus.id_dest_idx = rd;
    bus.id_class    = cls;
    bus.pipe_hold   = hold;
    bus.flush       = fl;
    e.nm = nm; e.stall = es; e.issue = ei; e.f0 = ef0; e.f1 = ef1; e.cnt = ec[3:0];
    q.push_back(e);
  endtask

  initial begin
    bus.id_valid = 1'b0; bus.id_src_idx = '0; bus.id_src_used = '0;
    bus.id_reg_wr = 1'b0; bus.id_dest_idx = '0; bus.id_class = '0;
    bus.pipe_hold = 1'b0; bus.flush = 1'b0;
    //   name        rn v  a0 a1 used  wr rd cls hold fl  st is f0 f1 cnt
    vec("rst",       0, 1, 5, 5, 2'b11, 1, 5, 0, 0, 0,  0, 1, 0, 0, 0);
    vec("alu_p",     1, 1, 0, 0, 2'b00, 1, 5, 0, 0, 0,  0, 1, 0, 0, 0);
    vec("alu_b2b",   1, 1, 5, 5, 2'b11, 1, 6, 0, 0, 0,  0, 1, 1, 1, 0);
    vec("alu_d2",    1, 1, 5, 0, 2'b11, 1, 7, 0, 0, 0,  0, 1, 2, 0, 0);
    vec("lw_x3",     1, 1, 0, 0, 2'b00, 1, 3, 1, 0, 0,  0, 1, 0, 0, 0);
    vec("lu_s1",     1, 1, 3, 1, 2'b11, 1, 4, 0, 0, 0,  1, 0, 0, 0, 0);
    vec("lu_s2",     1, 1, 3, 1, 2'b11, 1, 4, 0, 0, 0,  1, 0, 0, 0, 1);
    vec("lu_go",     1, 1, 3, 1, 2'b11, 1, 4, 0, 0, 0,  0, 1, 3, 0, 2);
    vec("addi_x2",   1, 1, 0, 0, 2'b00, 1, 2, 0, 0, 0,  0, 1, 0, 0, 2);
    vec("lw_x2",     1, 1, 0, 0, 2'b01, 1, 2, 1, 0, 0,  0, 1, 0, 0, 2);
    vec("yw_s1",     1, 1, 2, 0, 2'b01, 1, 10, 0, 0, 0, 1, 0, 0, 0, 2);
    vec("yw_s2",     1, 1, 2, 0, 2'b01, 1, 10, 0, 0, 0, 1, 0, 0, 0, 3);
    vec("yw_go",     1, 1, 2, 0, 2'b01, 1, 10, 0, 0, 0, 0, 1, 3, 0, 4);
    vec("wr_x0",     1, 1, 0, 0, 2'b00, 1, 0, 1, 0, 0,  0, 1, 0, 0, 4);
    vec("rd_x0",     1, 1, 0, 0, 2'b11, 1, 11, 0, 0, 0, 0, 1, 0, 0, 4);
    vec("lw_x9",     1, 1, 0, 0, 2'b00, 1, 9, 1, 0, 0,  0, 1, 0, 0, 4);
    vec("lui",       1, 1, 9, 9, 2'b00, 1, 12, 0, 0, 0, 0, 1, 0, 0, 4);
    vec("op1_s",     1, 1, 9, 9, 2'b10, 1, 13, 0, 0, 0, 1, 0, 0, 0, 4);
    vec("op1_go",    1, 1, 9, 9, 2'b10, 1, 13, 0, 0, 0, 0, 1, 0, 3, 5);
    vec("lw_x8",     1, 1, 0, 0, 2'b00, 1, 8, 1, 0, 0,  0, 1, 0, 0, 5);
    vec("flush",     1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1,  0, 0, 0, 0, 5);
    vec("fl_chk",    1, 1, 8, 0, 2'b01, 1, 14, 0, 0, 0, 0, 1, 0, 0, 5);
    vec("mul_x15",   1, 1, 0, 0, 2'b00, 1, 15, 2, 0, 0, 0, 1, 0, 0, 5);
    for (int i = 0; i < 3; i++)
      vec($sformatf("hold%0d", i), 1, 1, 15, 0, 2'b01, 1, 16, 0, 1, 0, 1, 0, 0, 0, 5 + i);
    vec("hold_rel",  1, 1, 15, 0, 2'b01, 1, 16, 0, 0, 0, 1, 0, 0, 0, 8);
    vec("mul_go",    1, 1, 15, 0, 2'b01, 1, 16, 0, 0, 0, 0, 1, 2, 0, 9);
    vec("mul_x17",   1, 1, 0, 0, 2'b00, 1, 17, 2, 0, 0, 0, 1, 0, 0, 9);
    vec("hold_fl",   1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1,  0, 0, 0, 0, 9);
    vec("hf_chk",    1, 1, 17, 16, 2'b11, 1, 18, 0, 0, 0, 0, 1, 0, 2, 9);
    vec("d3",        1, 1, 16, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3, 0, 9);
    vec("d4",        1, 1, 16, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
    vec("mul_x20",   1, 1, 0, 0, 2'b00, 1, 20, 2, 0, 0, 0, 1, 0, 0, 9);
    for (int i = 0; i < 20; i++)
      vec($sformatf("sat%0d", i), 1, 1, 20, 0, 2'b01, 1, 21, 0, 1, 0, 1, 0, 0, 0,
          (9 + i > 15) ? 15 : 9 + i);
    vec("sat_end",   1, 1, 20, 0, 2'b01, 1, 21, 0, 1, 0, 1, 0, 0, 0, 15);
    vec("rst_mid",   0, 1, 20, 0, 2'b01, 1, 21, 0, 1, 0, 0, 0, 0, 0, 0);
    vec("rst_mid2",  0, 1, 20, 0, 2'b01, 1, 21, 0, 0, 0, 0, 1, 0, 0, 0);
    vec("post_rst",  1, 1, 20, 0, 2'b01, 1, 21, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
